// File: rtl/bus_uart_pkg.sv
// bus_uart_pkg -- shared definitions for the bus_uart peripheral.
//   Register word offsets (addr[3:2]), STATUS bit positions, the state
//   encoding shared by the TX and RX serial engines, the divider width and
//   the divider clamp helper.
package bus_uart_pkg;

   localparam int DIV_W = 16;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_RXV   = 4;
   localparam int STAT_RXOVR = 5;
   localparam int STAT_FERR  = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   // A divider of zero would give a one-clock bit; the engines never run
   // faster than two clocks per bit.
   function automatic logic [DIV_W-1:0] div_clamp(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

endpackage

// File: rtl/bus_uart_fifo.sv
// sync_fifo -- single-clock FIFO used as the bus_uart TX byte queue.
//   clk/rst : clock, synchronous active-high reset (flushes the queue)
//   push/din: write request and data; accepted when not full, or when full
//             and a pop happens in the same cycle
//   pop/dout: read request; dout shows the head entry (valid when !empty)
//   full/empty/level: occupancy flags and entry count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign level   = count;
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   // A pop frees the slot the simultaneous push lands in.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bus_uart.sv
// bus_uart -- memory-mapped 8N1 UART behind the pipelined bus hub.
//   clk, rst        : core clock, synchronous active-high reset
//   addr/wdata/wmask: bus byte address, write data, byte-lane mask
//   wen/ren         : one-cycle write/read strobes, qualified by active
//   rdata/ready     : registered read data and one-cycle completion pulse
//   active          : combinational window decode BASE_ADDR..BASE_ADDR+15
//   tx              : serial output, idle high
//   rx              : serial input, used only when UART_RX_EN is defined
// Build option: `define UART_RX_EN adds the receiver and its STATUS bits.
module bus_uart
   import bus_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_2000,
   parameter int          CLK_HZ     = 50_000_000,
   parameter int          BAUD       = 115_200,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   input  logic        wen,
   input  logic        ren,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        active,
   output logic        tx,
   input  logic        rx
);

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_HZ / BAUD - 1);
   localparam int               LVL_W   = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]       off;
   logic             wr_hit, rd_hit, push;
   logic [DIV_W-1:0] div_reg, div_eff;
   logic             ovf;
   logic [31:0]      status_word, rd_word;
   logic [7:0]       fifo_dout;
   logic             fifo_full, fifo_empty, fifo_pop;
   logic [LVL_W-1:0] fifo_level;
   logic             unused_ok;

   assign active  = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 32'd16);
   assign off     = addr[3:2];
   assign wr_hit  = wen & active;
   assign rd_hit  = ren & active;
   assign push    = wr_hit && (off == OFF_DATA) && wmask[0];
   assign div_eff = div_clamp(div_reg);
   assign unused_ok = &{1'b0, wdata[31:16], wmask[3:2], rx};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (wdata[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // ---- TX engine ----
   uart_state_t      tx_state, tx_state_n;
   logic [DIV_W-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
   logic [2:0]       tx_bit, tx_bit_n;
   logic [7:0]       tx_sh, tx_sh_n;
   logic             tx_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx       <= tx_n;
      end
   end

   always_ff @(posedge clk) begin
      tx_sh  <= tx_sh_n;
      tx_div <= tx_div_n;
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_sh_n    = tx_sh;
      tx_div_n   = tx_div;
      tx_n       = 1'b1;
      fifo_pop   = 1'b0;
      case (tx_state)
         S_IDLE, S_STOP: begin
            if (tx_state == S_STOP && tx_cnt != '0) begin
               tx_cnt_n = tx_cnt - 1'b1;
            end else if (!fifo_empty) begin
               // The divider is sampled here so a DIV write never bends a frame.
               fifo_pop   = 1'b1;
               tx_state_n = S_START;
               tx_sh_n    = fifo_dout;
               tx_div_n   = div_eff;
               tx_cnt_n   = div_eff;
               tx_n       = 1'b0;
            end else begin
               tx_state_n = S_IDLE;
            end
         end
         S_START: begin
            tx_n = 1'b0;
            if (tx_cnt == '0) begin
               tx_state_n = S_DATA;
               tx_cnt_n   = tx_div;
               tx_bit_n   = '0;
               tx_n       = tx_sh[0];
            end else begin
               tx_cnt_n = tx_cnt - 1'b1;
            end
         end
         S_DATA: begin
            tx_n = tx_sh[0];
            if (tx_cnt == '0) begin
               tx_cnt_n = tx_div;
               tx_bit_n = tx_bit + 1'b1;
               if (tx_bit == 3'd7) begin
                  tx_state_n = S_STOP;
                  tx_n       = 1'b1;
               end else begin
                  tx_sh_n = {1'b0, tx_sh[7:1]};
                  tx_n    = tx_sh[1];
               end
            end else begin
               tx_cnt_n = tx_cnt - 1'b1;
            end
         end
         default: tx_state_n = S_IDLE;
      endcase
   end

`ifdef UART_RX_EN
   // ---- RX engine ----
   uart_state_t      rx_state, rx_state_n;
   logic [DIV_W-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]       rx_bit, rx_bit_n;
   logic [7:0]       rx_sh, rx_sh_n, rx_hold;
   logic             rx_s1, rx_s2, rx_done, rx_bad;
   logic             rx_valid, rx_ovr, rx_ferr, rd_data_clr;

   assign rd_data_clr = rd_hit && (off == OFF_DATA);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
      end
   end

   always_ff @(posedge clk) begin
      rx_sh <= rx_sh_n;
      if (rx_done && !(rx_valid && !rd_data_clr)) rx_hold <= rx_sh;
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      rx_done    = 1'b0;
      rx_bad     = 1'b0;
      case (rx_state)
         S_IDLE: begin
            if (!rx_s2) begin
               rx_state_n = S_START;
               rx_cnt_n   = div_eff >> 1;
            end
         end
         S_START: begin
            // Re-check at mid start bit; a short glitch returns to idle.
            if (rx_cnt != '0) begin
               rx_cnt_n = rx_cnt - 1'b1;
            end else if (!rx_s2) begin
               rx_state_n = S_DATA;
               rx_cnt_n   = div_eff;
               rx_bit_n   = '0;
            end else begin
               rx_state_n = S_IDLE;
            end
         end
         S_DATA: begin
            if (rx_cnt != '0) begin
               rx_cnt_n = rx_cnt - 1'b1;
            end else begin
               rx_sh_n  = {rx_s2, rx_sh[7:1]};
               rx_bit_n = rx_bit + 1'b1;
               rx_cnt_n = div_eff;
               if (rx_bit == 3'd7) rx_state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (rx_cnt != '0) begin
               rx_cnt_n = rx_cnt - 1'b1;
            end else begin
               rx_state_n = S_IDLE;
               rx_done    = rx_s2;
               rx_bad     = ~rx_s2;
            end
         end
         default: rx_state_n = S_IDLE;
      endcase
   end
`endif

   // ---- Register file and bus response ----
   always_comb begin
      status_word             = '0;
      status_word[STAT_FULL]  = fifo_full;
      status_word[STAT_EMPTY] = fifo_empty;
      status_word[STAT_BUSY]  = (tx_state != S_IDLE) | ~fifo_empty;
      status_word[STAT_OVF]   = ovf;
      status_word[15:8]       = 8'(fifo_level);
`ifdef UART_RX_EN
      status_word[STAT_RXV]   = rx_valid;
      status_word[STAT_RXOVR] = rx_ovr;
      status_word[STAT_FERR]  = rx_ferr;
`endif
      case (off)
`ifdef UART_RX_EN
         OFF_DATA:   rd_word = {23'd0, rx_valid, rx_valid ? rx_hold : 8'h00};
`else
         OFF_DATA:   rd_word = '0;
`endif
         OFF_STATUS: rd_word = status_word;
         OFF_DIV:    rd_word = {16'd0, div_reg};
         default:    rd_word = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready   <= 1'b0;
         rdata   <= '0;
         div_reg <= DIV_RST;
         ovf     <= 1'b0;
`ifdef UART_RX_EN
         rx_valid <= 1'b0;
         rx_ovr   <= 1'b0;
         rx_ferr  <= 1'b0;
`endif
      end else begin
         ready <= wr_hit | rd_hit;
         rdata <= rd_hit ? rd_word : '0;
         // Drop only when the engine is not freeing a slot this same edge.
         if (push && fifo_full && !fifo_pop) begin
            ovf <= 1'b1;
         end else if (wr_hit && off == OFF_STATUS && wmask[0] && wdata[STAT_OVF]) begin
            ovf <= 1'b0;
         end
         if (wr_hit && off == OFF_DIV) begin
            if (wmask[0]) div_reg[7:0]  <= wdata[7:0];
            if (wmask[1]) div_reg[15:8] <= wdata[15:8];
         end
`ifdef UART_RX_EN
         if (rx_done && rx_valid && !rd_data_clr) rx_ovr <= 1'b1;
         else if (wr_hit && off == OFF_STATUS && wmask[0] && wdata[STAT_RXOVR]) rx_ovr <= 1'b0;
         if (rx_bad) rx_ferr <= 1'b1;
         else if (wr_hit && off == OFF_STATUS && wmask[0] && wdata[STAT_FERR]) rx_ferr <= 1'b0;
         if (rx_done) rx_valid <= 1'b1;
         else if (rd_data_clr) rx_valid <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_bus_uart.sv
// tb_bus_uart -- directed bench for bus_uart (default build, RX disabled).
//   Register accesses come from a vector table; serial framing, overflow,
//   back-to-back frames and reset mid-frame are hand-written sequences.
module tb_bus_uart;

   localparam logic [31:0] BASE = 32'h8000_2000;
   localparam logic [1:0]  O_DATA = 2'd0, O_STAT = 2'd1, O_DIV = 2'd2, O_RSV = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  wmask;
   logic        wen, ren, ready, active, tx, rx;

   int checks = 0;
   int errors = 0;

   assign rx = tx;

   bus_uart dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .wdata  (wdata),
      .wmask  (wmask),
      .wen    (wen),
      .ren    (ren),
      .rdata  (rdata),
      .ready  (ready),
      .active (active),
      .tx     (tx),
      .rx     (rx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        wr;
      logic [1:0]  off;
      logic [31:0] wd;
      logic [3:0]  wm;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Entered and left at posedge+1; strobe is sampled on the edge in between.
   task automatic access(input logic wr, input logic [1:0] off, input logic [31:0] wd,
                         input logic [3:0] wm, output logic [31:0] rd);
      addr  = BASE + {28'd0, off, 2'b00};
      wdata = wd;
      wmask = wm;
      wen   = wr;
      ren   = ~wr;
      @(posedge clk); #1;
      wen = 1'b0;
      ren = 1'b0;
      check("ready_pulse", {79'd0, ready}, 80'd1);
      rd = rdata;
   endtask

   task automatic capture(input int n, output logic [79:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         v[i] = tx;
         @(posedge clk); #1;
      end
   endtask

   // Expected tx samples for one frame at DIV=3, sample 0 = first start-bit clock.
   function automatic logic [39:0] frame40(input logic [7:0] b);
      logic [39:0] f;
      for (int i = 0; i < 40; i++) begin
         int seg;
         seg = i / 4;
         if (seg == 0)      f[i] = 1'b0;
         else if (seg == 9) f[i] = 1'b1;
         else               f[i] = b[seg-1];
      end
      return f;
   endfunction

   initial begin
      logic [31:0] rd;
      logic [79:0] cap;

      vecs[0]  = '{1'b0, O_DIV,  32'h0,        4'h0, 32'd433,     "div_reset"};
      vecs[1]  = '{1'b0, O_STAT, 32'h0,        4'h0, 32'h0000_0002, "status_reset"};
      vecs[2]  = '{1'b0, O_DATA, 32'h0,        4'h0, 32'h0,       "data_read_zero"};
      vecs[3]  = '{1'b0, O_RSV,  32'h0,        4'h0, 32'h0,       "rsvd_read"};
      vecs[4]  = '{1'b1, O_RSV,  32'hFFFF_FFFF, 4'hF, 32'h0,      "rsvd_write"};
      vecs[5]  = '{1'b0, O_RSV,  32'h0,        4'h0, 32'h0,       "rsvd_after_write"};
      vecs[6]  = '{1'b1, O_DIV,  32'h0000_1234, 4'h1, 32'h0,      "div_wr_lane0"};
      vecs[7]  = '{1'b0, O_DIV,  32'h0,        4'h0, 32'h0000_0134, "div_lane0"};
      vecs[8]  = '{1'b1, O_DIV,  32'h0000_ABCD, 4'h2, 32'h0,      "div_wr_lane1"};
      vecs[9]  = '{1'b0, O_DIV,  32'h0,        4'h0, 32'h0000_AB34, "div_lane1"};
      vecs[10] = '{1'b1, O_DIV,  32'h0000_0003, 4'hF, 32'h0,      "div_wr3"};
      vecs[11] = '{1'b0, O_DIV,  32'h0,        4'h0, 32'h0000_0003, "div_3"};

      rst = 1'b1; addr = '0; wdata = '0; wmask = '0; wen = 1'b0; ren = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx",    {79'd0, tx},    80'd1);
      check("reset_ready", {79'd0, ready}, 80'd0);
      check("reset_rdata", {48'd0, rdata}, 80'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         access(vecs[i].wr, vecs[i].off, vecs[i].wd, vecs[i].wm, rd);
         check(vecs[i].name, {48'd0, rd}, {48'd0, vecs[i].exp});
      end
      @(posedge clk); #1;
      check("ready_single_cycle", {79'd0, ready}, 80'd0);
      check("rdata_idle_zero",    {48'd0, rdata}, 80'd0);

      // Window boundaries
      addr = BASE + 32'd16; ren = 1'b1; #1;
      check("active_above", {79'd0, active}, 80'd0);
      @(posedge clk); #1; ren = 1'b0;
      check("ready_above", {79'd0, ready}, 80'd0);
      addr = BASE - 32'd4; ren = 1'b1; #1;
      check("active_below", {79'd0, active}, 80'd0);
      @(posedge clk); #1; ren = 1'b0;
      check("ready_below", {79'd0, ready}, 80'd0);
      addr = BASE + 32'd12; #1;
      check("active_top_word", {79'd0, active}, 80'd1);

      // Single frame of 0x55 at DIV=3
      access(1'b1, O_DATA, 32'h55, 4'h1, rd);
      @(posedge clk); #1;
      capture(40, cap);
      check("frame_55", cap, {40'd0, frame40(8'h55)});
      access(1'b0, O_STAT, 32'h0, 4'h0, rd);
      check("status_after_frame", {48'd0, rd}, 80'h2);

      // Overflow: one byte moves into the shifter, sixteen fill the queue
      access(1'b1, O_DIV, 32'd1000, 4'hF, rd);
      for (int i = 0; i < 17; i++) access(1'b1, O_DATA, 32'(i), 4'h1, rd);
      access(1'b0, O_STAT, 32'h0, 4'h0, rd);
      check("status_full_no_ovf", {48'd0, rd}, 80'h1005);
      access(1'b1, O_DATA, 32'hEE, 4'h1, rd);
      access(1'b0, O_STAT, 32'h0, 4'h0, rd);
      check("status_ovf", {48'd0, rd}, 80'h100D);
      access(1'b1, O_STAT, 32'h8, 4'h1, rd);
      access(1'b0, O_STAT, 32'h0, 4'h0, rd);
      check("status_ovf_cleared", {48'd0, rd}, 80'h1005);

      // Reset during a start bit
      check("tx_in_start", {79'd0, tx}, 80'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("tx_after_rst", {79'd0, tx}, 80'd1);
      access(1'b0, O_STAT, 32'h0, 4'h0, rd);
      check("status_after_rst", {48'd0, rd}, 80'h2);
      access(1'b0, O_DIV, 32'h0, 4'h0, rd);
      check("div_after_rst", {48'd0, rd}, 80'd433);

      // Back-to-back frames: the second start bit follows the first stop bit
      access(1'b1, O_DIV, 32'd3, 4'hF, rd);
      access(1'b1, O_DATA, 32'hA1, 4'h1, rd);
      access(1'b1, O_DATA, 32'hB2, 4'h1, rd);
      capture(80, cap);
      check("frames_a1_b2", cap, {frame40(8'hB2), frame40(8'hA1)});
      access(1'b0, O_STAT, 32'h0, 4'h0, rd);
      check("busy_fell", {48'd0, rd}, 80'h2);

      // Reset at data bit 4 of 0x0F with 0x33 queued behind it
      access(1'b1, O_DATA, 32'h0F, 4'h1, rd);
      access(1'b1, O_DATA, 32'h33, 4'h1, rd);
      repeat (21) @(posedge clk);
      #1;
      check("tx_bit4", {79'd0, tx}, 80'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("tx_bit4_rst", {79'd0, tx}, 80'd1);
      access(1'b0, O_STAT, 32'h0, 4'h0, rd);
      check("status_flushed", {48'd0, rd}, 80'h2);
      capture(12, cap);
      check("tx_stays_idle", cap, 80'hFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
